spi_cmd_sequencer: RTL and testbench
====================================

# spi_cmd_sequencer

Sequences one SD-card SPI command/response transaction on the SPI bit clock. It frames and shifts out a 48-bit command, polls MISO for the response start bit within a bounded window, then captures a 1-byte (R1) or 5-byte (R3/R7) response. It sits between the card-init/transfer FSM, which issues commands, and the SPI pins. Its receive side replaces ad-hoc per-command byte readers.

## Interface
- CMD_BITS, 48, command frame length in bits
- MAX_RESP_BYTES, 5, longest response captured
- NCR_MAX, 80, max spiClock cycles spent polling for the response start bit
- spiClock  in  1  SPI bit clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  level request; held high for the whole transaction, dropped after done
- cmdIndex  in  6  command index; sampled on the accepting edge
- cmdArg  in  32  command argument; sampled on the accepting edge
- cmdCrc  in  7  CRC7; sampled on the accepting edge
- longResp  in  1  0 = 1-byte response, 1 = 5-byte response; sampled on the accepting edge
- miso  in  1  card data out
- mosi  out  1  card data in
- cs_n  out  1  card chip select, active-low
- busy  out  1  high from the accepting edge until return to IDLE
- done  out  1  transaction ended; held until start falls
- error  out  1  timeout flag; valid while done is high
- response  out  40  captured response, right-aligned; unused upper bits are 0

## Operation
- Reset values: mosi=1, cs_n=1, busy=0, done=0, error=0, response=0, state=IDLE.
- Command frame: {2'b01, cmdIndex, cmdArg, cmdCrc, 1'b1}, sent MSB first.
- IDLE: on an edge with start=1, latch the inputs and load the frame. Set cs_n=0, busy=1 and mosi=frame[47]. Go to SEND.
- SEND: shift one bit per edge. After the 48th bit has been driven for one cycle, go to WAIT with mosi=1.
- WAIT: sample miso on each edge.
  - miso=0 counts as response bit 7 of byte 0 and is stored. Go to READ.
  - If NCR_MAX samples pass with all miso=1, set error=1 and done=1, clear response, and go to HOLD.
- READ: shift miso into the capture register for a further 7 bits (longResp=0) or 39 bits (longResp=1). After the last bit is stored, set done=1 and go to HOLD.
- HOLD: cs_n=0 and mosi=1; response and error are stable. When start=0, clear done and error, set cs_n=1 and busy=0, and go to IDLE.
- Abort: start=0 in SEND, WAIT or READ returns to IDLE on that edge with cs_n=1, busy=0 and mosi=1. done and error stay 0 and response is unchanged.
- start high while in HOLD never restarts a transaction. A new command needs start low for at least one edge.
- Wait counter width is clog2(NCR_MAX+1). Bit counter width is clog2(max(CMD_BITS, 8*MAX_RESP_BYTES)). No wrap-around: counters are reloaded on every state entry.

## Timing
- Edge 0 accepts start; mosi carries frame bit 47 from edge 0 to edge 1, and frame bit 0 from edge 47 to edge 48.
- Edge 48 enters WAIT. The first miso sample is on edge 49.
- If the start bit is sampled on WAIT edge k (k=1..NCR_MAX): done is high after edge 48+k+7 (R1) or 48+k+39 (long response).
- Timeout: done=1 and error=1 after edge 48+NCR_MAX.
- Asynchronous reset during any state forces the reset values immediately. cs_n rises without waiting for an edge.

## Structure
- Shared package sd_spi_pkg holds:
  - the state enum (IDLE, SEND, WAIT, READ, HOLD)
  - CMD_BITS
  - the response-length constants R1_BITS=8 and R7_BITS=40
  - START_PREFIX=2'b01 and STOP_BIT=1'b1
- One sub-module, spi_rx_shifter: a MSB-first serial-in/parallel-out register with load-clear and shift-enable, width 8*MAX_RESP_BYTES. The sequencer owns all control.

## Test plan
- CMD0 (index 0, arg 0, crc 7'h4A, longResp=0), card drives 0x01 with its start bit on WAIT edge 3: mosi stream 0x400000000095, then done=1, error=0, response=40'h01 after edge 58.
- CMD8 (index 8, arg 0x1AA, crc 7'h43, longResp=1), card replies 0x01000001AA on WAIT edge 1: response=40'h01000001AA, done after edge 88.
- miso held at 1: done=1, error=1, response=0 after edge 128; both flags clear the edge after start falls, and cs_n=1.
- start dropped on SEND edge 20: next edge returns to IDLE with cs_n=1, busy=0, done=0; a new start then sends the full 48-bit frame again.
- Reset asserted mid-READ: outputs take their reset values asynchronously. After release with start high, a fresh transaction begins on the first edge.
- start kept high through HOLD for 20 edges: no second frame on mosi, done stays 1, response stays stable.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared SD SPI framing constants, sequencer states and frame builder
package sd_spi_pkg;

    localparam int CMD_BITS = 48;
    localparam int R1_BITS  = 8;
    localparam int R7_BITS  = 40;

    localparam logic [1:0] START_PREFIX = 2'b01;
    localparam logic       STOP_BIT     = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        WAIT = ST_WAIT,
        READ = ST_READ,
        HOLD = ST_HOLD
    } seq_state_e;

    function automatic logic [CMD_BITS-1:0] build_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        return {START_PREFIX, idx, arg, crc, STOP_BIT};
    endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// rtl/spi_rx_shifter.sv - MSB-first serial-in/parallel-out response register
// data_next is the register value after the current edge, so a caller can commit the final bit on the same edge.
module spi_rx_shifter #(
    parameter int WIDTH = 40
) (
    input  logic             spiClock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] data_next
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] base;

    always_comb begin
        base      = clear ? '0 : data;
        data_next = shift_en ? {base[WIDTH-2:0], sdi} : base;
    end

    always_ff @(posedge spiClock or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - one SD SPI command/response transaction: frame out, poll, capture R1/R7
module spi_cmd_sequencer
    import sd_spi_pkg::*;
#(
    parameter int CMD_BITS       = 48,
    parameter int MAX_RESP_BYTES = 5,
    parameter int NCR_MAX        = 80
) (
    input  logic                        spiClock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [5:0]                  cmdIndex,
    input  logic [31:0]                 cmdArg,
    input  logic [6:0]                  cmdCrc,
    input  logic                        longResp,
    input  logic                        miso,
    output logic                        mosi,
    output logic                        cs_n,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [8*MAX_RESP_BYTES-1:0] response
);

    localparam int RESP_W   = 8 * MAX_RESP_BYTES;
    localparam int BIT_SPAN = (CMD_BITS > RESP_W) ? CMD_BITS : RESP_W;
    localparam int BIT_W    = $clog2(BIT_SPAN);
    localparam int WAIT_W   = $clog2(NCR_MAX + 1);

    seq_state_e          state;
    logic [CMD_BITS-1:0] frame;
    logic [CMD_BITS-1:0] cmd_shift;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    last_bit;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                long_q;
    logic                rx_clear;
    logic                rx_shift;
    logic [RESP_W-1:0]   rx_next;

    assign frame    = build_frame(cmdIndex, cmdArg, cmdCrc);
    assign last_bit = long_q ? BIT_W'(R7_BITS - 1) : BIT_W'(R1_BITS - 1);

    // The start bit itself is bit 7 of byte 0, so it both clears and shifts in one edge.
    assign rx_clear = (state == WAIT) && start && !miso;
    assign rx_shift = rx_clear || ((state == READ) && start);

    spi_rx_shifter #(
        .WIDTH(RESP_W)
    ) u_rx_shifter (
        .spiClock (spiClock),
        .reset    (reset),
        .clear    (rx_clear),
        .shift_en (rx_shift),
        .sdi      (miso),
        .data_next(rx_next)
    );

    always_ff @(posedge spiClock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mosi      <= 1'b1;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            response  <= '0;
            cmd_shift <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            long_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_shift <= frame << 1;
                        mosi      <= frame[CMD_BITS-1];
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        long_q    <= longResp;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (!start) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        mosi  <= 1'b1;
                    end else if (bit_cnt == BIT_W'(CMD_BITS - 1)) begin
                        mosi     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        mosi      <= cmd_shift[CMD_BITS-1];
                        cmd_shift <= cmd_shift << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (!start) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        mosi  <= 1'b1;
                    end else if (!miso) begin
                        bit_cnt <= BIT_W'(1);
                        state   <= READ;
                    end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
                        error    <= 1'b1;
                        done     <= 1'b1;
                        response <= '0;
                        state    <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (!start) begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        mosi  <= 1'b1;
                    end else if (bit_cnt == last_bit) begin
                        response <= rx_next;
                        done     <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed and randomized transactions against a card/frame reference model
module tb_spi_cmd_sequencer;

    localparam int NCR = 80;

    logic        spiClock = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  cmdIndex;
    logic [31:0] cmdArg;
    logic [6:0]  cmdCrc;
    logic        longResp;
    logic        miso;
    logic        mosi;
    logic        cs_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [39:0] response;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] last_resp;

    always #5 spiClock = ~spiClock;

    spi_cmd_sequencer #(
        .CMD_BITS      (48),
        .MAX_RESP_BYTES(5),
        .NCR_MAX       (NCR)
    ) dut (
        .spiClock(spiClock),
        .reset   (reset),
        .start   (start),
        .cmdIndex(cmdIndex),
        .cmdArg  (cmdArg),
        .cmdCrc  (cmdCrc),
        .longResp(longResp),
        .miso    (miso),
        .mosi    (mosi),
        .cs_n    (cs_n),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .response(response)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge spiClock);
        #2;
    endtask

    // k = WAIT edge carrying the card's start bit (0 = card never answers).
    // stop_after >= 0 returns after that many edges, before any completion checks.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                           input logic lng, input int k, input logic [39:0] resp, input int stop_after);
        logic [47:0] exp_frame;
        logic [47:0] got_frame;
        logic [39:0] exp_resp;
        int          nbits;
        int          last_edge;
        int          j;
        exp_frame = {2'b01, idx, arg, crc, 1'b1};
        nbits     = lng ? 40 : 8;
        last_edge = (k == 0) ? 48 + NCR : 48 + k + nbits - 1;
        if (k == 0) exp_resp = '0;
        else if (lng) exp_resp = resp;
        else exp_resp = {32'h0, resp[7:0]};
        got_frame = '0;
        cmdIndex  = idx;
        cmdArg    = arg;
        cmdCrc    = crc;
        longResp  = lng;
        start     = 1'b1;
        miso      = 1'b1;
        for (int e = 0; e <= last_edge; e++) begin
            if (e == stop_after) return;
            step();
            if (e < 48) got_frame[47 - e] = mosi;
            if (e == 0) begin
                check("accept_busy", busy, 1);
                check("accept_cs_n", cs_n, 0);
                cmdIndex = 6'($urandom);
                cmdArg   = $urandom;
                cmdCrc   = 7'($urandom);
                longResp = ~lng;
            end
            if (e == last_edge - 1) check("done_early", done, 0);
            j = e + 1 - 48;
            miso = (k > 0 && j >= k && j < k + nbits) ? resp[nbits - 1 - (j - k)] : 1'b1;
        end
        check("frame", got_frame, exp_frame);
        check("done", done, 1);
        check("error", error, (k == 0) ? 1 : 0);
        check("response", response, exp_resp);
        check("hold_mosi", mosi, 1);
        check("hold_cs_n", cs_n, 0);
        check("hold_busy", busy, 1);
        last_resp = exp_resp;
    endtask

    task automatic release_start();
        start = 1'b0;
        step();
        check("rel_done", done, 0);
        check("rel_error", error, 0);
        check("rel_cs_n", cs_n, 1);
        check("rel_busy", busy, 0);
        check("rel_mosi", mosi, 1);
        check("rel_response", response, last_resp);
        miso = 1'b1;
    endtask

    initial begin
        logic [63:0] r;
        logic [39:0] rresp;
        logic        rl;
        int          rk;

        reset     = 1'b1;
        start     = 1'b0;
        miso      = 1'b1;
        cmdIndex  = '0;
        cmdArg    = '0;
        cmdCrc    = '0;
        longResp  = 1'b0;
        last_resp = '0;
        repeat (3) step();
        check("rst_mosi", mosi, 1);
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_response", response, 0);
        reset = 1'b0;
        step();
        check("idle_cs_n", cs_n, 1);
        check("idle_busy", busy, 0);

        // CMD0, R1 start bit on WAIT edge 3
        run_txn(6'd0, 32'h0, 7'h4A, 1'b0, 3, 40'h01, -1);
        release_start();

        // CMD8, R7 immediately, then start held through HOLD
        run_txn(6'd8, 32'h1AA, 7'h43, 1'b1, 1, 40'h01000001AA, -1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_no_frame", mosi, 1);
            check("hold_done", done, 1);
            check("hold_resp", response, 40'h01000001AA);
        end
        release_start();

        // card never answers
        run_txn(6'd55, 32'h0, 7'h32, 1'b0, 0, 40'h0, -1);
        release_start();

        // start bit on the very last poll
        run_txn(6'd41, 32'h40FF8000, 7'h3B, 1'b0, NCR, 40'h00, -1);
        release_start();

        // abort in SEND on edge 20
        run_txn(6'd17, 32'hDEADBEEF, 7'h11, 1'b0, 2, 40'h05, 20);
        start = 1'b0;
        step();
        check("abort_cs_n", cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mosi", mosi, 1);
        check("abort_resp", response, last_resp);
        run_txn(6'd17, 32'hDEADBEEF, 7'h11, 1'b0, 2, 40'h05, -1);
        release_start();

        // async reset in the middle of READ
        run_txn(6'd8, 32'h1AA, 7'h43, 1'b1, 2, 40'h01000001AA, 60);
        reset = 1'b1;
        #1;
        check("arst_cs_n", cs_n, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        check("arst_mosi", mosi, 1);
        check("arst_response", response, 0);
        last_resp = '0;
        #1;
        reset = 1'b0;
        run_txn(6'd58, 32'h0, 7'h7A, 1'b0, 5, 40'h00, -1);
        release_start();

        for (int t = 0; t < 10; t++) begin
            r     = {$urandom, $urandom};
            rl    = 1'($urandom);
            rk    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, NCR));
            rresp = rl ? {1'b0, r[38:0]} : {33'h0, r[6:0]};
            run_txn(6'($urandom), $urandom, 7'($urandom), rl, rk, rresp, -1);
            release_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
